// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter:
// FSM state encoding, parity mode codes and the frame data helpers.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;
   localparam logic [1:0] PAR_MARK = 2'b11;

   // Clears the bits above the configured data width (bits code 0..3 = 5..8 bits).
   function automatic logic [7:0] mask_data(input logic [7:0] data, input logic [1:0] bits);
      logic [7:0] mask;
      mask      = 8'hFF >> (2'd3 - bits);
      mask_data = data & mask;
   endfunction

   // Parity bit for already-masked data.
   function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] mode);
      logic even;
      even = ^data;
      case (mode)
         PAR_EVEN: calc_parity = even;
         PAR_ODD:  calc_parity = ~even;
         PAR_MARK: calc_parity = 1'b1;
         default:  calc_parity = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with registered full/empty flags and occupancy count.
// Push while full and pop while empty are ignored; push and pop together both proceed.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
)
(
   input  logic             i_Clock,
   input  logic             i_Rst_n,
   input  logic             i_Push,
   input  logic [7:0]       i_Din,
   input  logic             i_Pop,
   output logic [7:0]       o_Dout,
   output logic             o_Full,
   output logic             o_Empty,
   output logic [CNT_W-1:0] o_Count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [7:0]       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_full;
   logic             r_empty;
   logic             w_push_ok;
   logic             w_pop_ok;
   logic [CNT_W-1:0] w_count_nxt;

   assign w_push_ok = i_Push & ~r_full;
   assign w_pop_ok  = i_Pop & ~r_empty;

   // Next occupancy from the accepted push/pop pair.
   always_comb begin
      w_count_nxt = r_count;
      case ({w_push_ok, w_pop_ok})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Pointers, count and status flags; pointers wrap naturally at the power-of-2 depth.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CNT_W'(DEPTH));
         r_empty <= (w_count_nxt == CNT_W'(0));
      end
   end

   // Storage array, written only on an accepted push.
   always_ff @(posedge i_Clock) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_Din;
   end

   assign o_Dout  = r_mem[r_rd_ptr];
   assign o_Full  = r_full;
   assign o_Empty = r_empty;
   assign o_Count = r_count;

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: byte FIFO, runtime frame format, break generation.
// Frame format is latched when a byte leaves the FIFO, so config may change mid-frame.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 870,
   parameter int DIV_W        = 16,
   parameter int FIFO_DEPTH   = 4,
   parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
)
(
   input  logic             i_Clock,
   input  logic             i_Rst_n,
   input  logic             i_Tx_DV,
   input  logic [7:0]       i_Tx_Byte,
   output logic             o_Tx_Ready,
   input  logic [DIV_W-1:0] i_Cfg_Div,
   input  logic [1:0]       i_Cfg_Bits,
   input  logic [1:0]       i_Cfg_Parity,
   input  logic             i_Cfg_Stop2,
   input  logic             i_Break,
   output logic             o_Tx_Serial,
   output logic             o_Tx_Active,
   output logic             o_Tx_Done,
   output logic [CNT_W-1:0] o_Fifo_Count
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [DIV_W-1:0] r_clk_cnt;
   logic [DIV_W-1:0] w_cnt_nxt;
   logic [2:0]       r_bit_idx;
   logic [2:0]       w_bit_nxt;
   logic             r_serial;
   logic             w_serial_nxt;
   logic             r_active;
   logic             w_active_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             r_fifo_avail;

   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_bits;
   logic [1:0]       r_par;
   logic             r_stop2;
   logic [7:0]       r_data;
   logic             r_par_bit;

   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic [7:0]       w_fifo_dout;
   logic [7:0]       w_masked;
   logic [DIV_W-1:0] w_div_eff;
   logic             w_bit_end;
   logic [2:0]       w_last_idx;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .i_Clock (i_Clock),
      .i_Rst_n (i_Rst_n),
      .i_Push  (i_Tx_DV),
      .i_Din   (i_Tx_Byte),
      .i_Pop   (w_pop),
      .o_Dout  (w_fifo_dout),
      .o_Full  (w_full),
      .o_Empty (w_empty),
      .o_Count (o_Fifo_Count)
   );

   assign w_masked   = mask_data(w_fifo_dout, i_Cfg_Bits);
   assign w_div_eff  = (i_Cfg_Div < DIV_W'(2)) ? DIV_W'(2) : i_Cfg_Div;
   assign w_bit_end  = (r_clk_cnt == (r_div - DIV_W'(1)));
   assign w_last_idx = 3'(r_bits) + 3'd4;

   // Next-state and next-output decode for the frame sequencer.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_clk_cnt;
      w_bit_nxt    = r_bit_idx;
      w_serial_nxt = r_serial;
      w_active_nxt = r_active;
      w_done_nxt   = 1'b0;
      w_pop        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_serial_nxt = 1'b1;
            w_active_nxt = 1'b0;
            w_cnt_nxt    = '0;
            w_bit_nxt    = 3'd0;
            if (i_Break) begin
               w_state_nxt  = ST_BREAK;
               w_serial_nxt = 1'b0;
            end else if (r_fifo_avail && !w_empty) begin
               w_pop        = 1'b1;
               w_state_nxt  = ST_START;
               w_serial_nxt = 1'b0;
               w_active_nxt = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_START: begin
            if (w_bit_end) begin
               w_state_nxt  = ST_DATA;
               w_cnt_nxt    = '0;
               w_bit_nxt    = 3'd0;
               w_serial_nxt = r_data[0];
            end else begin
               w_cnt_nxt = r_clk_cnt + DIV_W'(1);
            end
         end
         ST_DATA: begin
            if (w_bit_end) begin
               w_cnt_nxt = '0;
               if (r_bit_idx == w_last_idx) begin
                  w_bit_nxt = 3'd0;
                  if (r_par != PAR_NONE) begin
                     w_state_nxt  = ST_PARITY;
                     w_serial_nxt = r_par_bit;
                  end else begin
                     w_state_nxt  = ST_STOP;
                     w_serial_nxt = 1'b1;
                  end
               end else begin
                  w_bit_nxt    = r_bit_idx + 3'd1;
                  w_serial_nxt = r_data[r_bit_idx + 3'd1];
               end
            end else begin
               w_cnt_nxt = r_clk_cnt + DIV_W'(1);
            end
         end
         ST_PARITY: begin
            if (w_bit_end) begin
               w_state_nxt  = ST_STOP;
               w_cnt_nxt    = '0;
               w_bit_nxt    = 3'd0;
               w_serial_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_clk_cnt + DIV_W'(1);
            end
         end
         ST_STOP: begin
            // r_bit_idx counts stop bits here; a second one is run only with Stop2.
            if (w_bit_end) begin
               w_cnt_nxt = '0;
               if (r_stop2 && (r_bit_idx == 3'd0)) begin
                  w_bit_nxt = 3'd1;
               end else begin
                  w_state_nxt  = ST_IDLE;
                  w_bit_nxt    = 3'd0;
                  w_serial_nxt = 1'b1;
                  w_active_nxt = 1'b0;
                  w_done_nxt   = 1'b1;
               end
            end else begin
               w_cnt_nxt = r_clk_cnt + DIV_W'(1);
            end
         end
         ST_BREAK: begin
            w_active_nxt = 1'b0;
            if (i_Break) begin
               w_serial_nxt = 1'b0;
            end else begin
               w_state_nxt  = ST_IDLE;
               w_serial_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt  = ST_IDLE;
            w_serial_nxt = 1'b1;
            w_active_nxt = 1'b0;
         end
      endcase
   end

   // Sequencer state, counters and registered line outputs.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_state      <= ST_IDLE;
         r_clk_cnt    <= '0;
         r_bit_idx    <= 3'd0;
         r_serial     <= 1'b1;
         r_active     <= 1'b0;
         r_done       <= 1'b0;
         r_fifo_avail <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_clk_cnt    <= w_cnt_nxt;
         r_bit_idx    <= w_bit_nxt;
         r_serial     <= w_serial_nxt;
         r_active     <= w_active_nxt;
         r_done       <= w_done_nxt;
         // FIFO status is staged one cycle before the sequencer acts on it.
         r_fifo_avail <= ~w_empty;
      end
   end

   // Frame-format registers, captured together with the byte as it leaves the FIFO.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_div     <= DIV_W'(CLKS_PER_BIT);
         r_bits    <= 2'b11;
         r_par     <= PAR_NONE;
         r_stop2   <= 1'b0;
         r_data    <= 8'h00;
         r_par_bit <= 1'b0;
      end else if (w_pop) begin
         r_div     <= w_div_eff;
         r_bits    <= i_Cfg_Bits;
         r_par     <= i_Cfg_Parity;
         r_stop2   <= i_Cfg_Stop2;
         r_data    <= w_masked;
         r_par_bit <= calc_parity(w_masked, i_Cfg_Parity);
      end
   end

   assign o_Tx_Ready  = ~w_full;
   assign o_Tx_Serial = r_serial;
   assign o_Tx_Active = r_active;
   assign o_Tx_Done   = r_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: stimulus queues the hand-derived line pattern of each
// frame; a monitor checks the serial line, Active and Done against it cycle by cycle.
module tb_uart_tx_cfg;

   localparam int DIV_W = 16;
   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   logic             clk;
   logic             rst_n;
   logic             i_Tx_DV;
   logic [7:0]       i_Tx_Byte;
   logic             o_Tx_Ready;
   logic [DIV_W-1:0] i_Cfg_Div;
   logic [1:0]       i_Cfg_Bits;
   logic [1:0]       i_Cfg_Parity;
   logic             i_Cfg_Stop2;
   logic             i_Break;
   logic             o_Tx_Serial;
   logic             o_Tx_Active;
   logic             o_Tx_Done;
   logic [CNT_W-1:0] o_Fifo_Count;

   int    n_cmp = 0;
   int    n_err = 0;
   int    spurious_done = 0;
   string q_seq[$];
   int    q_div[$];

   uart_tx_cfg #(
      .CLKS_PER_BIT (870),
      .DIV_W        (DIV_W),
      .FIFO_DEPTH   (DEPTH),
      .CNT_W        (CNT_W)
   ) dut (
      .i_Clock      (clk),
      .i_Rst_n      (rst_n),
      .i_Tx_DV      (i_Tx_DV),
      .i_Tx_Byte    (i_Tx_Byte),
      .o_Tx_Ready   (o_Tx_Ready),
      .i_Cfg_Div    (i_Cfg_Div),
      .i_Cfg_Bits   (i_Cfg_Bits),
      .i_Cfg_Parity (i_Cfg_Parity),
      .i_Cfg_Stop2  (i_Cfg_Stop2),
      .i_Break      (i_Break),
      .o_Tx_Serial  (o_Tx_Serial),
      .o_Tx_Active  (o_Tx_Active),
      .o_Tx_Done    (o_Tx_Done),
      .o_Fifo_Count (o_Fifo_Count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // seq: one character per bit period in line order (start, data LSB first, parity, stops).
   task automatic expect_frame(input string seq, input int div);
      q_seq.push_back(seq);
      q_div.push_back(div);
   endtask

   task automatic write_byte(input logic [7:0] b);
      i_Tx_DV   = 1'b1;
      i_Tx_Byte = b;
      tick(1);
      i_Tx_DV   = 1'b0;
   endtask

   task automatic set_cfg(input int div, input logic [1:0] bits, input logic [1:0] par, input logic s2);
      i_Cfg_Div    = DIV_W'(div);
      i_Cfg_Bits   = bits;
      i_Cfg_Parity = par;
      i_Cfg_Stop2  = s2;
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while ((q_seq.size() != 0 || o_Tx_Active || o_Fifo_Count != '0) && t < 3000) begin
         tick(1);
         t++;
      end
      chk({name, "_drain_in_time"}, 32'(t < 3000), 32'd1);
      tick(3);
   endtask

   task automatic wait_active(input string name);
      int t;
      t = 0;
      while (!o_Tx_Active && t < 200) begin
         tick(1);
         t++;
      end
      chk({name, "_active_seen"}, 32'(o_Tx_Active), 32'd1);
   endtask

   // Monitor: each frame consumes one scoreboard entry and every Active cycle of the DUT.
   initial begin
      string s;
      int    div;
      int    bad;
      bit    aborted;
      logic  exp_bit;
      forever begin
         @(negedge clk);
         if (!rst_n) continue;
         if (o_Tx_Done) spurious_done++;
         if (o_Tx_Active) begin
            if (q_seq.size() == 0) begin
               chk("unexpected_frame", 32'd1, 32'd0);
               for (int w = 0; w < 2000 && o_Tx_Active; w++) @(negedge clk);
            end else begin
               s   = q_seq.pop_front();
               div = q_div.pop_front();
               bad = 0;
               aborted = 1'b0;
               for (int k = 0; k < s.len() * div; k++) begin
                  if (k > 0) @(negedge clk);
                  if (!rst_n) begin
                     aborted = 1'b1;
                     break;
                  end
                  exp_bit = (s[k / div] == 8'h31);
                  if (o_Tx_Active !== 1'b1 || o_Tx_Serial !== exp_bit || o_Tx_Done !== 1'b0) bad++;
               end
               if (!aborted) begin
                  chk({"frame_line_", s}, 32'(bad), 32'd0);
                  @(negedge clk);
                  chk({"frame_end_", s}, {30'd0, o_Tx_Done, o_Tx_Active}, 32'd2);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      rst_n     = 1'b0;
      i_Tx_DV   = 1'b0;
      i_Tx_Byte = 8'h00;
      i_Break   = 1'b0;
      set_cfg(4, 2'b11, 2'b00, 1'b0);
      tick(3);
      chk("rst_serial", 32'(o_Tx_Serial), 32'd1);
      chk("rst_active", 32'(o_Tx_Active), 32'd0);
      chk("rst_done",   32'(o_Tx_Done),   32'd0);
      chk("rst_count",  32'(o_Fifo_Count), 32'd0);
      chk("rst_ready",  32'(o_Tx_Ready),  32'd1);
      rst_n = 1'b1;
      tick(3);

      // 8N1 0x55 with start-bit latency check.
      expect_frame("0101010101", 4);
      write_byte(8'h55);
      chk("count_after_write", 32'(o_Fifo_Count), 32'd1);
      tick(1);
      chk("latency_edge1_high", 32'(o_Tx_Serial), 32'd1);
      tick(1);
      chk("latency_edge2_low", 32'(o_Tx_Serial), 32'd0);
      drain("t1");

      // 7E2 0x41.
      set_cfg(4, 2'b10, 2'b01, 1'b1);
      expect_frame("01000001011", 4);
      write_byte(8'h41);
      drain("t2");

      // 5O1 0xFF: upper bits dropped.
      set_cfg(4, 2'b00, 2'b10, 1'b0);
      expect_frame("01111101", 4);
      write_byte(8'hFF);
      drain("t3");

      // 8M1 0x00 with divisor 0 floored to 2.
      set_cfg(0, 2'b11, 2'b11, 1'b0);
      expect_frame("00000000011", 2);
      write_byte(8'h00);
      drain("t3m");

      // FIFO fill: six consecutive writes, the sixth is dropped.
      set_cfg(4, 2'b11, 2'b00, 1'b0);
      expect_frame("0100000001", 4);
      expect_frame("0010000001", 4);
      expect_frame("0110000001", 4);
      expect_frame("0001000001", 4);
      expect_frame("0101000001", 4);
      i_Tx_DV = 1'b1;
      for (int i = 0; i < 6; i++) begin
         i_Tx_Byte = 8'(i + 1);
         if (i == 5) chk("ready_low_when_full", 32'(o_Tx_Ready), 32'd0);
         tick(1);
      end
      i_Tx_DV = 1'b0;
      chk("count_full", 32'(o_Fifo_Count), 32'd4);
      drain("t4");
      chk("count_empty", 32'(o_Fifo_Count), 32'd0);

      // Reset during data bit 3 of 0xA5.
      expect_frame("0101001011", 4);
      write_byte(8'hA5);
      wait_active("t5");
      repeat (18) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_serial", 32'(o_Tx_Serial), 32'd1);
      chk("async_rst_active", 32'(o_Tx_Active), 32'd0);
      chk("async_rst_count",  32'(o_Fifo_Count), 32'd0);
      tick(2);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         tick(1);
         if (o_Tx_Serial !== 1'b1 || o_Tx_Active !== 1'b0) bad++;
      end
      chk("idle_after_reset", 32'(bad), 32'd0);

      // Break in IDLE holds a queued byte.
      i_Break = 1'b1;
      tick(3);
      chk("break_line_low", 32'(o_Tx_Serial), 32'd0);
      expect_frame("0001111001", 4);
      write_byte(8'h3C);
      tick(3);
      chk("break_line_still_low", 32'(o_Tx_Serial), 32'd0);
      chk("break_byte_held", 32'(o_Fifo_Count), 32'd1);
      chk("break_active_low", 32'(o_Tx_Active), 32'd0);
      i_Break = 1'b0;
      tick(1);
      chk("break_release_high", 32'(o_Tx_Serial), 32'd1);
      drain("t6a");

      // Break requested mid-frame waits for the frame to finish.
      expect_frame("0111100001", 4);
      write_byte(8'h0F);
      wait_active("t6b");
      tick(5);
      i_Break = 1'b1;
      bad = 0;
      while (!o_Tx_Done && bad < 200) begin
         tick(1);
         bad++;
      end
      chk("t6b_done_seen", 32'(o_Tx_Done), 32'd1);
      tick(1);
      chk("break_after_frame_low", 32'(o_Tx_Serial), 32'd0);
      chk("break_after_frame_inactive", 32'(o_Tx_Active), 32'd0);
      i_Break = 1'b0;
      tick(2);

      // Divisor change mid-frame applies only to the next frame.
      expect_frame("0100000011", 4);
      expect_frame("0011111101", 8);
      write_byte(8'h81);
      write_byte(8'h7E);
      wait_active("t6c");
      tick(3);
      i_Cfg_Div = DIV_W'(8);
      drain("t6c");

      chk("no_spurious_done", 32'(spurious_done), 32'd0);
      chk("scoreboard_empty", 32'(q_seq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
